// File: rtl/vend_pkg.sv
// Shared types and defaults for the change dispenser: change codes, FSM states,
// default sizes and the tube-count update rule.
package vend_pkg;

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_TUBE_MAX   = 15;
  localparam int CNT_W          = 4;
  localparam int N_TUBES        = 2;

  // Tube index 0 holds 5-unit coins, tube 1 holds 10-unit coins.
  localparam int TUBE5  = 0;
  localparam int TUBE10 = 1;

  typedef enum logic [1:0] {
    CHG_NONE = 2'b00,
    CHG_5    = 2'b01,
    CHG_10   = 2'b10,
    CHG_15   = 2'b11
  } change_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SELECT,
    ST_REQ,
    ST_RELEASE
  } state_t;

  // A refill and a dispense on the same tube cancel; a refill into a full
  // tube is silently dropped.
  function automatic logic [CNT_W-1:0] tube_next(
    input logic [CNT_W-1:0] cnt,
    input logic             inc,
    input logic             dec,
    input logic [CNT_W-1:0] max_cnt
  );
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && dec) begin
      res = cnt;
    end else if (dec) begin
      res = cnt - CNT_W'(1);
    end else if (inc && (cnt != max_cnt)) begin
      res = cnt + CNT_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/change_fifo.sv
// Small circular FIFO of pending change codes. A push into a full FIFO is
// dropped even when a pop happens in the same cycle.
module change_fifo
  import vend_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] din,
  output logic [1:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [1:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: queues change requests and pays each one out greedily
// (10-unit coins first) through two hoppers with a 4-phase req/ack handshake.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TUBE_MAX   = DEF_TUBE_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       change,
  output logic             hop5_req,
  output logic             hop10_req,
  input  logic             hop5_ack,
  input  logic             hop10_ack,
  input  logic             refill_en,
  input  logic             refill_sel,
  output logic [CNT_W-1:0] cnt5,
  output logic [CNT_W-1:0] cnt10,
  output logic             busy,
  output logic             overflow,
  output logic             short_pay
);

  localparam logic [CNT_W-1:0] TUBE_FULL = CNT_W'(TUBE_MAX);

  state_t     state_q, state_d;
  logic [1:0] rem_q, rem_d;
  logic       coin10_q, coin10_d;
  logic       short_pay_q, short_pay_d;
  logic       overflow_q, overflow_d;

  change_t    change_code;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [1:0] fifo_dout;
  logic       sel_ack;
  logic [1:0] coin_val;

  logic [N_TUBES-1:0]            refill_hit;
  logic [N_TUBES-1:0]            dispense;
  logic [N_TUBES-1:0][CNT_W-1:0] cnt_all;

  assign change_code = change_t'(change);
  assign fifo_push   = (change_code != CHG_NONE);

  change_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (change),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // One saturating counter per tube; gi matches the tube index (0 = 5, 1 = 10).
  for (genvar gi = 0; gi < N_TUBES; gi++) begin : g_tube
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign refill_hit[gi] = refill_en && (refill_sel == 1'(gi));

    always_comb begin
      cnt_d = tube_next(cnt_q, refill_hit[gi], dispense[gi], TUBE_FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_all[gi] = cnt_q;
  end

  assign sel_ack  = coin10_q ? hop10_ack : hop5_ack;
  assign coin_val = coin10_q ? 2'd2 : 2'd1;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    coin10_d    = coin10_q;
    short_pay_d = 1'b0;
    fifo_pop    = 1'b0;
    dispense    = '0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        fifo_pop = 1'b1;
        rem_d    = fifo_dout;
        state_d  = ST_SELECT;
      end
      ST_SELECT: begin
        if (rem_q == 2'd0) begin
          state_d = ST_IDLE;
        end else if ((rem_q >= 2'd2) && (cnt_all[TUBE10] != '0)) begin
          coin10_d = 1'b1;
          state_d  = ST_REQ;
        end else if (cnt_all[TUBE5] != '0) begin
          coin10_d = 1'b0;
          state_d  = ST_REQ;
        end else begin
          // Nothing left that fits: abandon the remainder of this request.
          short_pay_d = 1'b1;
          rem_d       = 2'd0;
          state_d     = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (sel_ack) begin
          dispense[coin10_q] = 1'b1;
          rem_d              = rem_q - coin_val;
          state_d            = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!sel_ack) begin
          state_d = ST_SELECT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign overflow_d = overflow_q || (fifo_push && fifo_full);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= 2'd0;
      coin10_q    <= 1'b0;
      short_pay_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      coin10_q    <= coin10_d;
      short_pay_q <= short_pay_d;
      overflow_q  <= overflow_d;
    end
  end

  // Requests decode straight from the state so reset drops them at once.
  assign hop5_req  = (state_q == ST_REQ) && !coin10_q;
  assign hop10_req = (state_q == ST_REQ) && coin10_q;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);
  assign overflow  = overflow_q;
  assign short_pay = short_pay_q;
  assign cnt5      = cnt_all[TUBE5];
  assign cnt10     = cnt_all[TUBE10];

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus randomized
// refills/requests checked against a greedy coin-payout reference model.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] change = 2'b00;
  logic       hop5_ack = 1'b0;
  logic       hop10_ack = 1'b0;
  logic       refill_en = 1'b0;
  logic       refill_sel = 1'b0;
  logic       hop5_req;
  logic       hop10_req;
  logic [3:0] cnt5;
  logic [3:0] cnt10;
  logic       busy;
  logic       overflow;
  logic       short_pay;

  int n_checks = 0;
  int n_fail = 0;

  // Hopper responder control: 0 = acks driven by the test, 1 = automatic.
  int ack_mode = 0;
  int ack_delay = 2;
  bit rand_delay = 1'b0;
  int short_seen = 0;
  int pair_err = 0;
  int coins[$];

  change_dispenser #(
    .FIFO_DEPTH (4),
    .TUBE_MAX   (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .change     (change),
    .hop5_req   (hop5_req),
    .hop10_req  (hop10_req),
    .hop5_ack   (hop5_ack),
    .hop10_ack  (hop10_ack),
    .refill_en  (refill_en),
    .refill_sel (refill_sel),
    .cnt5       (cnt5),
    .cnt10      (cnt10),
    .busy       (busy),
    .overflow   (overflow),
    .short_pay  (short_pay)
  );

  always #5 clk = ~clk;

  // Negedge monitor and automatic hopper: records each accepted coin.
  initial begin : responder
    int age;
    int cur_delay;
    age = 0;
    cur_delay = 0;
    forever begin
      @(negedge clk);
      if (hop5_req && hop10_req) pair_err++;
      if (short_pay) short_seen++;
      if (ack_mode != 0) begin
        if (hop5_req || hop10_req) begin
          if (age >= cur_delay) begin
            hop5_ack = hop5_req;
            hop10_ack = hop10_req;
          end
          age++;
          if (hop5_req && hop5_ack) coins.push_back(5);
          if (hop10_req && hop10_ack) coins.push_back(10);
        end else begin
          hop5_ack = 1'b0;
          hop10_ack = 1'b0;
          age = 0;
          cur_delay = rand_delay ? int'($urandom_range(0, 3)) : ack_delay;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic refill(input logic sel, input int n);
    refill_sel = sel;
    refill_en = 1'b1;
    repeat (n) @(negedge clk);
    refill_en = 1'b0;
  endtask

  task automatic send(input logic [1:0] c);
    change = c;
    @(negedge clk);
    change = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy && !hop5_req && !hop10_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_req(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (hop5_req || hop10_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    step(3);
    n_checks++; if (hop5_req !== 1'b0 || hop10_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b%0b expected 00", hop10_req, hop5_req); end
    n_checks++; if (cnt5 !== 4'd0 || cnt10 !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got cnt5=%0d cnt10=%0d expected 0/0", cnt5, cnt10); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (overflow !== 1'b0 || short_pay !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ovf=%0b short=%0b expected 0/0", overflow, short_pay); end
    rst = 1'b1;
    step(2);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %0b expected 0", busy); end
    $display("test_reset: done");
  endtask

  task automatic test_latency();
    bit ok;
    ack_mode = 0;
    refill(1'b0, 1);
    send(2'b01);
    n_checks++; if (hop5_req !== 1'b0) begin n_fail++; $display("FAIL lat_push: hop5_req=%0b expected 0", hop5_req); end
    step(1);
    n_checks++; if (hop5_req !== 1'b0) begin n_fail++; $display("FAIL lat_load: hop5_req=%0b expected 0", hop5_req); end
    step(1);
    n_checks++; if (hop5_req !== 1'b0) begin n_fail++; $display("FAIL lat_select: hop5_req=%0b expected 0", hop5_req); end
    step(1);
    n_checks++; if (hop5_req !== 1'b1 || hop10_req !== 1'b0) begin n_fail++; $display("FAIL lat_req: got req10/5=%0b%0b expected 01", hop10_req, hop5_req); end
    hop10_ack = 1'b1;
    step(2);
    n_checks++; if (hop5_req !== 1'b1 || cnt5 !== 4'd1) begin n_fail++; $display("FAIL foreign_ack: got hop5_req=%0b cnt5=%0d expected 1/1", hop5_req, cnt5); end
    hop10_ack = 1'b0;
    hop5_ack = 1'b1;
    step(1);
    n_checks++; if (hop5_req !== 1'b0 || cnt5 !== 4'd0) begin n_fail++; $display("FAIL ack_take: got hop5_req=%0b cnt5=%0d expected 0/0", hop5_req, cnt5); end
    step(2);
    n_checks++; if (hop5_req !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL release_hold: got req=%0b busy=%0b expected 0/1", hop5_req, busy); end
    hop5_ack = 1'b0;
    wait_idle(20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL lat_idle: busy=%0b expected 0 within bound", busy); end
    $display("test_latency: cnt5=%0d", cnt5);
  endtask

  task automatic test_mixed();
    bit ok;
    int c0, c1;
    refill(1'b1, 1);
    refill(1'b0, 2);
    n_checks++; if (cnt10 !== 4'd1 || cnt5 !== 4'd2) begin n_fail++; $display("FAIL mixed_refill: got cnt10=%0d cnt5=%0d expected 1/2", cnt10, cnt5); end
    coins.delete();
    short_seen = 0;
    rand_delay = 1'b0;
    ack_delay = 2;
    ack_mode = 1;
    send(2'b11);
    wait_idle(100, ok);
    step(2);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mixed_idle: busy=%0b expected 0 within bound", busy); end
    c0 = (coins.size() > 0) ? coins[0] : -1;
    c1 = (coins.size() > 1) ? coins[1] : -1;
    n_checks++; if (coins.size() != 2 || c0 != 10 || c1 != 5) begin n_fail++; $display("FAIL mixed_order: got n=%0d first=%0d second=%0d expected 2/10/5", coins.size(), c0, c1); end
    n_checks++; if (cnt10 !== 4'd0 || cnt5 !== 4'd1) begin n_fail++; $display("FAIL mixed_cnt: got cnt10=%0d cnt5=%0d expected 0/1", cnt10, cnt5); end
    n_checks++; if (short_seen != 0) begin n_fail++; $display("FAIL mixed_short: got %0d pulses expected 0", short_seen); end
    $display("test_mixed: coins=%0d cnt10=%0d cnt5=%0d", coins.size(), cnt10, cnt5);
  endtask

  task automatic test_fives();
    bit ok;
    int c0, c1;
    refill(1'b0, 2);
    coins.delete();
    short_seen = 0;
    send(2'b10);
    wait_idle(100, ok);
    step(2);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL fives_idle: busy=%0b expected 0 within bound", busy); end
    c0 = (coins.size() > 0) ? coins[0] : -1;
    c1 = (coins.size() > 1) ? coins[1] : -1;
    n_checks++; if (coins.size() != 2 || c0 != 5 || c1 != 5) begin n_fail++; $display("FAIL fives_order: got n=%0d first=%0d second=%0d expected 2/5/5", coins.size(), c0, c1); end
    n_checks++; if (cnt5 !== 4'd1 || cnt10 !== 4'd0) begin n_fail++; $display("FAIL fives_cnt: got cnt5=%0d cnt10=%0d expected 1/0", cnt5, cnt10); end
    $display("test_fives: coins=%0d cnt5=%0d", coins.size(), cnt5);
  endtask

  task automatic test_short();
    do_reset();
    coins.delete();
    short_seen = 0;
    send(2'b01);
    step(8);
    n_checks++; if (short_seen != 1) begin n_fail++; $display("FAIL short_pulse: got %0d cycles expected 1", short_seen); end
    n_checks++; if (coins.size() != 0 || hop5_req !== 1'b0 || hop10_req !== 1'b0) begin n_fail++; $display("FAIL short_noreq: got coins=%0d expected 0", coins.size()); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL short_busy: got %0b expected 0", busy); end
    $display("test_short: pulses=%0d", short_seen);
  endtask

  task automatic test_overflow();
    bit ok;
    ack_mode = 0;
    refill(1'b0, 10);
    send(2'b01);
    wait_req(20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_stall: no req within bound, expected hop5_req"); end
    change = 2'b01;
    repeat (4) @(negedge clk);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at_depth: got %0b expected 0", overflow); end
    @(negedge clk);
    change = 2'b00;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0b expected 1", overflow); end
    // Finish the stalled coin by hand, then push while the full FIFO pops.
    hop5_ack = 1'b1;
    step(1);
    hop5_ack = 1'b0;
    step(3);
    change = 2'b11;
    step(1);
    change = 2'b00;
    coins.delete();
    short_seen = 0;
    rand_delay = 1'b0;
    ack_delay = 1;
    ack_mode = 1;
    wait_idle(300, ok);
    step(2);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_idle: busy=%0b expected 0 within bound", busy); end
    n_checks++; if (coins.size() != 4) begin n_fail++; $display("FAIL ovf_served: got %0d coins expected 4", coins.size()); end
    n_checks++; if (cnt5 !== 4'd5) begin n_fail++; $display("FAIL ovf_cnt5: got %0d expected 5", cnt5); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
    $display("test_overflow: served=%0d cnt5=%0d", coins.size(), cnt5);
  endtask

  task automatic test_refill_collision();
    bit ok;
    do_reset();
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %0b expected 0", overflow); end
    ack_mode = 0;
    refill(1'b0, 2);
    send(2'b01);
    wait_req(20, ok);
    n_checks++; if (!ok || hop5_req !== 1'b1) begin n_fail++; $display("FAIL coll_req: hop5_req=%0b expected 1", hop5_req); end
    hop5_ack = 1'b1;
    refill_sel = 1'b0;
    refill_en = 1'b1;
    step(1);
    refill_en = 1'b0;
    n_checks++; if (cnt5 !== 4'd2 || hop5_req !== 1'b0) begin n_fail++; $display("FAIL coll_cnt5: got cnt5=%0d req=%0b expected 2/0", cnt5, hop5_req); end
    hop5_ack = 1'b0;
    wait_idle(20, ok);
    refill(1'b0, 20);
    n_checks++; if (cnt5 !== 4'd15) begin n_fail++; $display("FAIL sat_cnt5: got %0d expected 15", cnt5); end
    refill(1'b0, 1);
    n_checks++; if (cnt5 !== 4'd15) begin n_fail++; $display("FAIL sat_stay: got %0d expected 15", cnt5); end
    refill(1'b1, 17);
    n_checks++; if (cnt10 !== 4'd15) begin n_fail++; $display("FAIL sat_cnt10: got %0d expected 15", cnt10); end
    $display("test_refill_collision: cnt5=%0d cnt10=%0d", cnt5, cnt10);
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    ack_mode = 0;
    refill(1'b1, 1);
    send(2'b10);
    wait_req(20, ok);
    n_checks++; if (!ok || hop10_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req: hop10_req=%0b expected 1", hop10_req); end
    rst = 1'b0;
    #1;
    n_checks++; if (hop10_req !== 1'b0 || hop5_req !== 1'b0) begin n_fail++; $display("FAIL rmid_drop: got req10/5=%0b%0b expected 00", hop10_req, hop5_req); end
    n_checks++; if (cnt10 !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_state: got cnt10=%0d busy=%0b expected 0/0", cnt10, busy); end
    step(1);
    rst = 1'b1;
    step(1);
    refill(1'b1, 1);
    hop10_ack = 1'b1;
    hop5_ack = 1'b1;
    step(4);
    n_checks++; if (hop10_req !== 1'b0 || hop5_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stray_ack_req: got req=%0b%0b busy=%0b expected 00/0", hop10_req, hop5_req, busy); end
    n_checks++; if (cnt10 !== 4'd1 || cnt5 !== 4'd0) begin n_fail++; $display("FAIL stray_ack_cnt: got cnt10=%0d cnt5=%0d expected 1/0", cnt10, cnt5); end
    hop10_ack = 1'b0;
    hop5_ack = 1'b0;
    $display("test_reset_mid: cnt10=%0d", cnt10);
  endtask

  task automatic test_random();
    bit ok;
    int m5, m10, exp_short, rem, n5, n10, blen;
    int exp_coins[$];
    logic [1:0] codes[3];
    bit seq_bad;
    do_reset();
    m5 = 0;
    m10 = 0;
    rand_delay = 1'b1;
    ack_mode = 1;
    for (int it = 0; it < 25; it++) begin
      coins.delete();
      exp_coins.delete();
      short_seen = 0;
      exp_short = 0;
      n5 = $urandom_range(0, 4);
      n10 = $urandom_range(0, 3);
      if (n5 > 0) refill(1'b0, n5);
      if (n10 > 0) refill(1'b1, n10);
      m5 = (m5 + n5 > 15) ? 15 : m5 + n5;
      m10 = (m10 + n10 > 15) ? 15 : m10 + n10;
      blen = $urandom_range(1, 3);
      for (int k = 0; k < blen; k++) codes[k] = 2'($urandom_range(0, 3));
      for (int k = 0; k < blen; k++) begin
        change = codes[k];
        @(negedge clk);
      end
      change = 2'b00;
      // Greedy payout: largest coin that fits, short when nothing fits.
      for (int k = 0; k < blen; k++) begin
        rem = int'(codes[k]);
        while (rem > 0) begin
          if (rem >= 2 && m10 > 0) begin
            exp_coins.push_back(10); m10--; rem -= 2;
          end else if (m5 > 0) begin
            exp_coins.push_back(5); m5--; rem -= 1;
          end else begin
            exp_short++; rem = 0;
          end
        end
      end
      wait_idle(300, ok);
      step(2);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rnd_idle it=%0d: busy=%0b expected 0 within bound", it, busy); end
      seq_bad = (coins.size() != exp_coins.size());
      for (int k = 0; k < coins.size() && !seq_bad; k++) if (coins[k] != exp_coins[k]) seq_bad = 1'b1;
      n_checks++; if (seq_bad) begin n_fail++; $display("FAIL rnd_coins it=%0d: got %0d coins expected %0d (sequence differs)", it, coins.size(), exp_coins.size()); end
      n_checks++; if (short_seen != exp_short) begin n_fail++; $display("FAIL rnd_short it=%0d: got %0d expected %0d", it, short_seen, exp_short); end
      n_checks++; if (int'(cnt5) != m5 || int'(cnt10) != m10) begin n_fail++; $display("FAIL rnd_cnt it=%0d: got cnt5=%0d cnt10=%0d expected %0d/%0d", it, cnt5, cnt10, m5, m10); end
      $display("rnd it=%0d burst=%0d coins=%0d short=%0d cnt5=%0d cnt10=%0d", it, blen, coins.size(), short_seen, cnt5, cnt10);
    end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rnd_ovf: got %0b expected 0", overflow); end
    n_checks++; if (pair_err != 0) begin n_fail++; $display("FAIL req_exclusive: both reqs high in %0d cycles expected 0", pair_err); end
    ack_mode = 0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_mixed();
    test_fives();
    test_short();
    test_overflow();
    test_refill_collision();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
